iterative_shift_unit: RTL and testbench
=======================================

// Module: iterative_shift_unit
// PURPOSE
//  Parametrised multi-cycle shifter; generalises the fixed shift-left-by-2 offset path.
//  Performs SLL/SRL/SRA by a run-time amount, one bit position per clock, with a start/done
//  handshake. Sits beside the ALU for variable shifts (sllv/srlv/srav) and reuses for
//  branch-offset scaling (SLL by 2).
// PARAMETERS
//  WIDTH    32                 data width in bits (>=2)
//  SHAMT_W  $clog2(WIDTH)      shift-amount width; max shift WIDTH-1
// PORTS
//  clk       in   1        rising-edge clock
//  reset     in   1        asynchronous, active-high reset
//  start     in   1        request; sampled only in IDLE or DONE
//  op        in   2        00 SLL, 01 SRL, 10 SRA, 11 ROR (macro) / pass-through
//  shamt     in   SHAMT_W  shift amount, captured with start
//  data_in   in   WIDTH    operand, captured with start
//  busy      out  1        high while in SHIFT
//  done      out  1        one-cycle pulse, result valid
//  data_out  out  WIDTH    result; held stable from done until next accepted start
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, busy=0, done=0, data_out=0, counter=0.
//  - FSM states: IDLE, SHIFT, DONE.
//    IDLE : start=1 -> capture data_in/op/shamt into work reg/counter;
//           shamt!=0 -> SHIFT, shamt==0 or pass-through op -> DONE.
//    SHIFT: each cycle shift work reg 1 bit per op, counter-1; counter reaches 0 -> DONE.
//    DONE : done=1 for exactly this cycle; data_out=work reg. start=1 here is accepted
//           (same rules as IDLE) giving back-to-back ops; else -> IDLE.
//  - start while busy is ignored; no queueing. Operands are not re-sampled mid-op.
//  - Latency: done high in cycle N+1 after the accepting edge, N=shamt (N=0 -> 1 cycle).
//  - 1-bit step: SLL {w[W-2:0],0}; SRL {0,w[W-1:1]}; SRA {w[W-1],w[W-1:1]}.
//  - data_out updates only on entry to DONE; during SHIFT it holds previous result.
//  - busy = (state==SHIFT); busy and done never both high.
//  - shamt = WIDTH-1 is max; SRA by WIDTH-1 yields all sign bits.
//  - Reset mid-SHIFT aborts; no done pulse is produced for the aborted op.
// CONFIGURATION
//  SHIFT_ROTATE_EN defined : op 11 = ROR, step {w[0],w[W-1:1]}, same timing as shifts.
//  SHIFT_ROTATE_EN absent  : op 11 = pass-through; shamt ignored, goes straight to DONE,
//                            done 1 cycle later with data_out=data_in.
// TESTING
//  1) reset mid-SHIFT (SLL 0x1 by 20, reset at cycle 5) -> busy=0,done=0,data_out=0 next;
//     no later done.
//  2) SLL 0x0000_0003 shamt=2 -> done in cycle 3, data_out=0x0000_000C; busy 2 cycles.
//  3) SRA 0x8000_0000 shamt=31 -> data_out=0xFFFF_FFFF; SRL same -> 0x0000_0001 at cycle 32.
//  4) shamt=0 SRL 0xDEAD_BEEF -> done 1 cycle later, data_out=0xDEAD_BEEF, busy never high.
//  5) start pulsed during SHIFT with new operands -> ignored; result of first op unchanged;
//     start in DONE cycle -> second op accepted, second done at expected latency.
//  6) op=11, 0x0000_0001 shamt=4: with SHIFT_ROTATE_EN -> 0x1000_0000 at cycle 5;
//     without -> 0x0000_0001 at cycle 1.

Source files
------------

// File: rtl/iterative_shift_unit.sv
// Multi-cycle SLL/SRL/SRA shifter, one bit position per clock, start/done handshake.
// Optional macro SHIFT_ROTATE_EN turns op 2'b11 into ROR; otherwise op 2'b11 is pass-through.
module iterative_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data_out,
  output logic [1:0]         dbg_state
);

  // Handshake: start is a request accepted on any rising edge where the unit is
  // not busy (IDLE or DONE); done pulses for one cycle with data_out valid and the
  // result stays on data_out until the next accepted request completes.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  state_t             r_state;
  logic [WIDTH-1:0]   r_work;
  logic [SHAMT_W-1:0] r_count;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_data_out;

  state_t             w_state_nxt;
  logic [WIDTH-1:0]   w_work_nxt;
  logic [SHAMT_W-1:0] w_count_nxt;
  logic [1:0]         w_op_nxt;
  logic [WIDTH-1:0]   w_data_out_nxt;
  logic [WIDTH-1:0]   w_step;
  logic               w_passthru;

`ifdef SHIFT_ROTATE_EN
  assign w_passthru = 1'b0;
`else
  assign w_passthru = (op == OP_ROR);
`endif

  // One-bit step of the captured operation applied to the work register.
  always_comb begin
    w_step = r_work;
    case (r_op)
      OP_SLL:  w_step = {r_work[WIDTH-2:0], 1'b0};
      OP_SRL:  w_step = {1'b0, r_work[WIDTH-1:1]};
      OP_SRA:  w_step = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
`ifdef SHIFT_ROTATE_EN
      OP_ROR:  w_step = {r_work[0], r_work[WIDTH-1:1]};
`endif
      default: w_step = r_work;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_work_nxt     = r_work;
    w_count_nxt    = r_count;
    w_op_nxt       = r_op;
    w_data_out_nxt = r_data_out;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_work_nxt  = data_in;
          w_op_nxt    = op;
          w_count_nxt = shamt;
          if ((shamt == '0) || w_passthru) begin
            w_state_nxt    = S_DONE;
            w_data_out_nxt = data_in;
          end else begin
            w_state_nxt = S_SHIFT;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        w_work_nxt  = w_step;
        w_count_nxt = r_count - SHAMT_W'(1);
        // Counter hits zero on this step: the stepped value is the final result.
        if (r_count <= SHAMT_W'(1)) begin
          w_state_nxt    = S_DONE;
          w_data_out_nxt = w_step;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_work     <= '0;
      r_count    <= '0;
      r_op       <= OP_SLL;
      r_data_out <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_work     <= w_work_nxt;
      r_count    <= w_count_nxt;
      r_op       <= w_op_nxt;
      r_data_out <= w_data_out_nxt;
    end
  end

  assign busy      = (r_state == S_SHIFT);
  assign done      = (r_state == S_DONE);
  assign data_out  = r_data_out;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Self-checking bench for iterative_shift_unit: directed cases plus chained random ops,
// scoreboard of expected result / done cycle / busy length. Honours SHIFT_ROTATE_EN.
module tb_iterative_shift_unit;
  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [SW-1:0] shamt = '0;
  logic [W-1:0]  data_in = '0;
  logic          busy, done;
  logic [W-1:0]  data_out;
  logic [1:0]    dbg_state;

  iterative_shift_unit #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .shamt(shamt),
    .data_in(data_in), .busy(busy), .done(done), .data_out(data_out),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           exp_busy_q[$];
  int           busy_cnt = 0;
  logic [W-1:0] hold_exp = '0;

  function automatic logic [W-1:0] model(input logic [1:0] o, input int s, input logic [W-1:0] d);
    case (o)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return W'($signed(d) >>> s);
`ifdef SHIFT_ROTATE_EN
      default: return (d >> s) | ((s == 0) ? '0 : (d << (W - s)));
`else
      default: return d;
`endif
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] o, input int s);
`ifdef SHIFT_ROTATE_EN
    return s;
`else
    return (o == 2'b11) ? 0 : s;
`endif
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
      hold_exp = '0;
    end else begin
      if (busy && done) check("busy_done_excl", 1, 0);
      if (busy) begin
        busy_cnt++;
        check("hold_during_shift", data_out, hold_exp);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          hold_exp = exp_q.pop_front();
          check("data_out", data_out, hold_exp);
          check("done_cycle", cyc, exp_cyc_q.pop_front());
          check("busy_cycles", busy_cnt, exp_busy_q.pop_front());
        end
        busy_cnt = 0;
      end
    end
  end

  // driver: called at a negedge, returns at the following negedge with start low
  task automatic start_op(input logic [1:0] o, input int s, input logic [W-1:0] d,
                          input bit accept);
    int l;
    start = 1'b1; op = o; shamt = SW'(s); data_in = d;
    if (accept) begin
      l = lat_of(o, s);
      exp_q.push_back(model(o, s, d));
      exp_cyc_q.push_back(cyc + 1 + l);
      exp_busy_q.push_back(l);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("timeout", exp_q.size(), 0);
      exp_q.delete(); exp_cyc_q.delete(); exp_busy_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [1:0] ro;
    int         rs, rl;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_data_out", data_out, 0);
    check("reset_state", dbg_state, 0);
    reset = 1'b0;
    @(negedge clk);

    // reset mid-SHIFT aborts the op
    start_op(2'b00, 20, 32'h1, 0);
    repeat (4) @(negedge clk);
    check("pre_abort_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_data_out", data_out, 0);
    check("abort_state", dbg_state, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);

    // directed operations
    start_op(2'b00, 2, 32'h0000_0003, 1);   wait_idle();
    start_op(2'b10, 31, 32'h8000_0000, 1);  wait_idle();
    start_op(2'b01, 31, 32'h8000_0000, 1);  wait_idle();
    start_op(2'b01, 0, 32'hDEAD_BEEF, 1);   wait_idle();
    start_op(2'b11, 4, 32'h0000_0001, 1);   wait_idle();
    start_op(2'b10, 4, 32'h7000_0000, 1);   wait_idle();

    // start during SHIFT ignored; start in DONE cycle accepted
    start_op(2'b00, 5, 32'h0000_0003, 1);
    @(negedge clk);
    start_op(2'b01, 3, 32'h0000_FFFF, 0);
    repeat (3) @(negedge clk);
    check("done_for_chain", done, 1);
    start_op(2'b10, 4, 32'h8000_0000, 1);
    wait_idle();

    // random ops chained back-to-back through the DONE cycle
    ro = 2'($urandom_range(0, 3));
    rs = $urandom_range(0, 31);
    for (int i = 0; i < 20; i++) begin
      rl = lat_of(ro, rs);
      start_op(ro, rs, $urandom, 1);
      repeat (rl) @(negedge clk);
      ro = 2'($urandom_range(0, 3));
      rs = $urandom_range(0, 31);
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
